// File: rtl/peripheral_spi_slave_if.sv
// J1 I/O bus plus SPI pins of the SPI slave peripheral, bundled for port connection.
interface peripheral_spi_slave_if;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic        sck;
    logic        ss;
    logic        mosi;
    logic        miso;

    modport master (
        output d_in, cs, addr, rd, wr, sck, ss, mosi,
        input  d_out, miso
    );

    modport slave (
        input  d_in, cs, addr, rd, wr, sck, ss, mosi,
        output d_out, miso
    );
endinterface

// File: rtl/peripheral_spi_slave.sv
// SPI mode-0 slave (8-bit, MSB first) with J1 register port; reads return on d_out one cycle later.
// No backpressure: bus accesses are taken every cycle; a byte arriving before the last is read sets overrun.
module peripheral_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    peripheral_spi_slave_if.slave  bus
);

    localparam int CW = SYNC_STAGES + 1;
    localparam int FW = $clog2(SYNC_STAGES + 2);
    localparam logic [FW-1:0] FLUSH_DONE = FW'(SYNC_STAGES + 1);

    localparam logic [3:0] ADDR_TX     = 4'h0;
    localparam logic [3:0] ADDR_RX     = 4'h2;
    localparam logic [3:0] ADDR_BUSY   = 4'h4;
    localparam logic [3:0] ADDR_AVAIL  = 4'h6;
    localparam logic [3:0] ADDR_STATUS = 4'h8;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    // sck/ss chains carry one extra stage: the previous synchronized sample for edge detection
    logic [CW-1:0]          sck_sync_q, sck_sync_d;
    logic [CW-1:0]          ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [FW-1:0]          flush_q, flush_d;

    logic [7:0]  tx_reg_q, tx_reg_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        avail_q, avail_d;
    logic        overrun_q, overrun_d;
    logic        txrdy_q, txrdy_d;
    logic        byte_done_q, byte_done_d;
    logic [15:0] d_out_q, d_out_d;

    logic sync_ok;
    logic sck_cur, sck_prev, ss_cur, ss_prev, mosi_s;
    logic sck_rise, sck_fall, ss_rise, ss_fall;
    logic rd_hit, wr_tx, rd_rx, rd_status;
    logic unused_d_in;

    assign unused_d_in = ^bus.d_in[15:8];

    // Edges are ignored until every chain stage holds a real pin sample, so reset
    // values cannot fake an ss falling edge while the master still holds ss low.
    assign sync_ok  = (flush_q == FLUSH_DONE);
    assign sck_cur  = sck_sync_q[SYNC_STAGES-1];
    assign sck_prev = sck_sync_q[SYNC_STAGES];
    assign ss_cur   = ss_sync_q[SYNC_STAGES-1];
    assign ss_prev  = ss_sync_q[SYNC_STAGES];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise = sync_ok &  sck_cur & ~sck_prev;
    assign sck_fall = sync_ok & ~sck_cur &  sck_prev;
    assign ss_rise  = sync_ok &  ss_cur  & ~ss_prev;
    assign ss_fall  = sync_ok & ~ss_cur  &  ss_prev;

    assign rd_hit    = bus.cs & bus.rd;
    assign wr_tx     = bus.cs & bus.wr & (bus.addr == ADDR_TX);
    assign rd_rx     = rd_hit & (bus.addr == ADDR_RX);
    assign rd_status = rd_hit & (bus.addr == ADDR_STATUS);

    always_comb begin
        state_d     = state_q;
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-1:0], bus.sck};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-1:0], bus.ss};
        mosi_sync_d = SYNC_STAGES'({mosi_sync_q, bus.mosi});
        flush_d     = sync_ok ? flush_q : flush_q + 1'b1;
        tx_reg_d    = tx_reg_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        avail_d     = avail_q;
        overrun_d   = overrun_q;
        txrdy_d     = txrdy_q;
        byte_done_d = byte_done_q;
        d_out_d     = '0;

        if (rd_hit) begin
            case (bus.addr)
                ADDR_RX:     d_out_d[7:0] = rx_data_q;
                ADDR_BUSY:   d_out_d[0]   = (state_q == SHIFT);
                ADDR_AVAIL:  d_out_d[0]   = avail_q;
                ADDR_STATUS: d_out_d[1:0] = {txrdy_q, overrun_q};
                default:     d_out_d      = '0;
            endcase
        end

        if (wr_tx)     tx_reg_d  = bus.d_in[7:0];
        if (rd_rx)     avail_d   = 1'b0;
        if (rd_status) overrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d     = SHIFT;
                    tx_shift_d  = tx_reg_q;
                    txrdy_d     = 1'b1;
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    byte_done_d = 1'b0;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    byte_done_d = 1'b0;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d   = {rx_shift_q[6:0], mosi_s};
                        avail_d     = 1'b1;
                        byte_done_d = 1'b1;
                        // a read of the old byte on this very cycle consumes it, so no overrun
                        if (avail_q && !rd_rx) overrun_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (byte_done_q) begin
                        tx_shift_d  = tx_reg_q;
                        txrdy_d     = 1'b1;
                        byte_done_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A tx_reg write on the reload cycle still leaves txrdy clear.
        if (wr_tx) txrdy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            flush_q     <= '0;
            tx_reg_q    <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            avail_q     <= 1'b0;
            overrun_q   <= 1'b0;
            txrdy_q     <= 1'b1;
            byte_done_q <= 1'b0;
            d_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            flush_q     <= flush_d;
            tx_reg_q    <= tx_reg_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            avail_q     <= avail_d;
            overrun_q   <= overrun_d;
            txrdy_q     <= txrdy_d;
            byte_done_q <= byte_done_d;
            d_out_q     <= d_out_d;
        end
    end

    assign bus.d_out = d_out_q;
    assign bus.miso  = (state_q == SHIFT) ? tx_shift_q[7] : 1'b0;

endmodule
